// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type, default widths and arithmetic helpers for the psum sequencer
package conv_pkg;

  localparam int CONV_IN_W  = 19;
  localparam int CONV_SUM_W = CONV_IN_W + 2;
  // Working width for the helpers; wide enough that no accumulator width can overflow it
  localparam int CONV_MAX_W = 64;

  typedef enum logic [1:0] {
    COLLECT,
    ISSUE,
    ACCUM,
    OUT
  } conv_state_e;

  // Sign-extend a raw adder result to the helper working width
  function automatic logic signed [CONV_MAX_W-1:0] sext_sum(input logic signed [CONV_SUM_W-1:0] i_s);
    return CONV_MAX_W'(i_s);
  endfunction

  // Add two values already inside a w-bit signed range, clamping the sum to that range
  function automatic logic signed [CONV_MAX_W-1:0] sat_add(
    input  logic signed [CONV_MAX_W-1:0] i_a,
    input  logic signed [CONV_MAX_W-1:0] i_b,
    input  int                           i_w,
    output logic                         o_ovf
  );
    logic signed [CONV_MAX_W-1:0] s;
    logic signed [CONV_MAX_W-1:0] hi;
    logic signed [CONV_MAX_W-1:0] lo;
    s     = i_a + i_b;
    hi    = (64'sd1 <<< (i_w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    o_ovf = 1'b0;
    if (s > hi) begin
      o_ovf = 1'b1;
      s     = hi;
    end else if (s < lo) begin
      o_ovf = 1'b1;
      s     = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/conv_acc_unit.sv
// rtl/conv_acc_unit.sv - channel accumulator with optional saturation (macro CONV_ACC_SAT_EN)
module conv_acc_unit
  import conv_pkg::*;
#(
  parameter int SUM_W = CONV_SUM_W,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_capture,
  input  logic             i_first,
  input  logic [SUM_W-1:0] i_sum,
  output logic [ACC_W-1:0] o_result,
  output logic             o_sat
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_sum_ext;
  logic signed [ACC_W-1:0] w_res;

  // First channel of a pixel starts from zero instead of the previous total
  always_comb begin
    w_base    = i_first ? '0 : r_acc;
    w_sum_ext = ACC_W'(sext_sum(i_sum));
  end

`ifdef CONV_ACC_SAT_EN
  logic w_ovf;
  logic r_sat;

  // Clamped accumulate; overflow indication comes back from the helper
  always_comb begin
    w_ovf = 1'b0;
    w_res = ACC_W'(sat_add(CONV_MAX_W'(w_base), CONV_MAX_W'(w_sum_ext), ACC_W, w_ovf));
  end

  // Sticky per pixel: restarts on the first channel, then ORs in every clamping step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (i_clear) begin
      r_sat <= 1'b0;
    end else if (i_capture) begin
      r_sat <= w_ovf | (r_sat & ~i_first);
    end
  end

  assign o_sat = r_sat;
`else
  // Plain two's-complement accumulate, wrapping modulo 2^ACC_W
  always_comb begin
    w_res = w_base + w_sum_ext;
  end

  assign o_sat = 1'b0;
`endif

  // Accumulator register, loaded once per channel while the adder result is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_capture) begin
      r_acc <= w_res;
    end
  end

  assign o_result = w_res;

endmodule

// File: rtl/conv_psum_sequencer.sv
// rtl/conv_psum_sequencer.sv - drives the shared 3-input psum adder and accumulates NUM_CH channels (macro CONV_ACC_SAT_EN)
module conv_psum_sequencer
  import conv_pkg::*;
#(
  parameter int   IN_W   = CONV_IN_W,
  parameter int   SUM_W  = IN_W + 2,
  parameter int   ACC_W  = 24,
  parameter int   NUM_CH = 4,
  localparam int  CNT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  input  logic [IN_W-1:0]  in_c,
  output logic             add_en,
  output logic [IN_W-1:0]  add_in1,
  output logic [IN_W-1:0]  add_in2,
  output logic [IN_W-1:0]  add_in3,
  input  logic [SUM_W-1:0] add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] ch_cnt,
  output logic             sat_flag
);

  conv_state_e      r_state, w_state_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_add_en, w_add_en_nxt;
  logic [IN_W-1:0]  r_in1, r_in2, r_in3;
  logic [IN_W-1:0]  w_in1_nxt, w_in2_nxt, w_in3_nxt;
  logic [CNT_W-1:0] r_ch, w_ch_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [ACC_W-1:0] r_out_data, w_out_data_nxt;
  logic             w_capture;
  logic             w_first;
  logic [ACC_W-1:0] w_result;

  // The adder only drives a real sum in ACCUM, so that is the only capture point
  assign w_capture = (r_state == ACCUM) & ~clear;
  assign w_first   = (r_ch == '0);

  conv_acc_unit #(
    .SUM_W (SUM_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (clear),
    .i_capture (w_capture),
    .i_first   (w_first),
    .i_sum     (add_sum),
    .o_result  (w_result),
    .o_sat     (sat_flag)
  );

  // Next-state and registered-output values; clear overrides every state
  always_comb begin
    w_state_nxt     = r_state;
    w_ready_nxt     = r_ready;
    w_add_en_nxt    = 1'b0;
    w_in1_nxt       = r_in1;
    w_in2_nxt       = r_in2;
    w_in3_nxt       = r_in3;
    w_ch_nxt        = r_ch;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    if (clear) begin
      w_state_nxt     = COLLECT;
      w_ready_nxt     = 1'b1;
      w_ch_nxt        = '0;
      w_out_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          w_ready_nxt = 1'b1;
          if (in_valid && r_ready) begin
            w_in1_nxt    = in_a;
            w_in2_nxt    = in_b;
            w_in3_nxt    = in_c;
            w_add_en_nxt = 1'b1;
            w_ready_nxt  = 1'b0;
            w_state_nxt  = ISSUE;
          end
        end
        ISSUE: begin
          w_ready_nxt = 1'b0;
          w_state_nxt = ACCUM;
        end
        ACCUM: begin
          if (r_ch == CNT_W'(NUM_CH - 1)) begin
            w_out_data_nxt  = w_result;
            w_out_valid_nxt = 1'b1;
            w_ch_nxt        = '0;
            w_ready_nxt     = 1'b0;
            w_state_nxt     = OUT;
          end else begin
            w_ch_nxt    = r_ch + CNT_W'(1);
            w_ready_nxt = 1'b1;
            w_state_nxt = COLLECT;
          end
        end
        OUT: begin
          w_ready_nxt = 1'b0;
          if (out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_ready_nxt     = 1'b1;
            w_state_nxt     = COLLECT;
          end
        end
        default: begin
          w_state_nxt = COLLECT;
          w_ready_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= COLLECT;
      r_ready     <= 1'b0;
      r_add_en    <= 1'b0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_in3       <= '0;
      r_ch        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= w_ready_nxt;
      r_add_en    <= w_add_en_nxt;
      r_in1       <= w_in1_nxt;
      r_in2       <= w_in2_nxt;
      r_in3       <= w_in3_nxt;
      r_ch        <= w_ch_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
    end
  end

  // A triple offered alongside clear must not be taken
  assign in_ready  = r_ready & ~clear;
  assign add_en    = r_add_en;
  assign add_in1   = r_in1;
  assign add_in2   = r_in2;
  assign add_in3   = r_in3;
  assign ch_cnt    = r_ch;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_conv_psum_sequencer.sv
// tb/tb_conv_psum_sequencer.sv - directed self-checking bench for conv_psum_sequencer (24b and 22b accumulators)
module tb_conv_psum_sequencer;

  localparam int IN_W   = 19;
  localparam int SUM_W  = 21;
  localparam int NUM_CH = 4;

`ifdef CONV_ACC_SAT_EN
  localparam int EXP3_B     = 2097151;
  localparam int EXP3_B_SAT = 1;
`else
  localparam int EXP3_B     = -1048588;
  localparam int EXP3_B_SAT = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic            in_valid;
  logic [IN_W-1:0] in_a, in_b, in_c;
  logic            out_ready;

  logic             in_ready_a, add_en_a, out_valid_a, sat_a;
  logic [IN_W-1:0]  a1_a, a2_a, a3_a;
  logic [SUM_W-1:0] sum_a;
  logic [23:0]      out_data_a;
  logic [1:0]       ch_cnt_a;

  logic             in_ready_b, add_en_b, out_valid_b, sat_b;
  logic [IN_W-1:0]  a1_b, a2_b, a3_b;
  logic [SUM_W-1:0] sum_b;
  logic [21:0]      out_data_b;
  logic [1:0]       ch_cnt_b;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int en_cnt      = 0;
  int dbl_cnt     = 0;
  logic prev_en   = 1'b0;
  int hs_cyc, ov_cyc, t0, en_base, dbl_base;

  always #5 clk = ~clk;

  conv_psum_sequencer #(.IN_W(IN_W), .SUM_W(SUM_W), .ACC_W(24), .NUM_CH(NUM_CH)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .add_en(add_en_a),
    .add_in1(a1_a), .add_in2(a2_a), .add_in3(a3_a), .add_sum(sum_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .ch_cnt(ch_cnt_a), .sat_flag(sat_a)
  );

  conv_psum_sequencer #(.IN_W(IN_W), .SUM_W(SUM_W), .ACC_W(22), .NUM_CH(NUM_CH)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .add_en(add_en_b),
    .add_in1(a1_b), .add_in2(a2_b), .add_in3(a3_b), .add_sum(sum_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .ch_cnt(ch_cnt_b), .sat_flag(sat_b)
  );

  // Shared registered adders: sum of the three operands one cycle later, 0 when disabled
  always @(posedge clk) begin
    sum_a <= add_en_a ? (SUM_W'($signed(a1_a)) + SUM_W'($signed(a2_a)) + SUM_W'($signed(a3_a))) : '0;
    sum_b <= add_en_b ? (SUM_W'($signed(a1_b)) + SUM_W'($signed(a2_b)) + SUM_W'($signed(a3_b))) : '0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // add_en pulse bookkeeping sampled mid-cycle
  always @(negedge clk) begin
    if (add_en_a) en_cnt <= en_cnt + 1;
    if (add_en_a && prev_en) dbl_cnt <= dbl_cnt + 1;
    prev_en <= add_en_a;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int a, input int b, input int c);
    int n;
    @(negedge clk);
    in_a     = IN_W'(a);
    in_b     = IN_W'(b);
    in_c     = IN_W'(c);
    in_valid = 1'b1;
    n = 0;
    while (in_ready_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_wait", in_ready_a, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hs_cyc   = cyc;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    @(negedge clk);
    while (out_valid_a !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("out_valid_wait", out_valid_a, 1);
    ov_cyc = cyc;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_in_ready_b", in_ready_b, 0);
    chk("rst_add_en", add_en_a, 0);
    chk("rst_add_in1", a1_a, 0);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data", $signed(out_data_a), 0);
    chk("rst_ch_cnt", ch_cnt_a, 0);
    chk("rst_sat", sat_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready_a, 1);
    chk("post_rst_in_ready_b", in_ready_b, 1);

    // 1: basic sum 6+15+24+33 = 78, result in cycle 12 after first handshake
    out_ready = 1'b1;
    #1;
    en_base = en_cnt; dbl_base = dbl_cnt;
    send(1, 2, 3);
    t0 = hs_cyc;
    chk("t1_add_en_issue", add_en_a, 1);
    send(4, 5, 6);
    send(7, 8, 9);
    send(10, 11, 12);
    wait_out();
    chk("t1_latency", ov_cyc - t0 + 1, 12);
    chk("t1_out_data", $signed(out_data_a), 78);
    chk("t1_ch_cnt", ch_cnt_a, 0);
    chk("t1_in_ready_out", in_ready_a, 0);
    chk("t1_sat", sat_a, 0);
    @(negedge clk);
    chk("t1_out_valid_drop", out_valid_a, 0);
    chk("t1_in_ready_back", in_ready_a, 1);
    #1;
    chk("t1_add_en_pulses", en_cnt - en_base, 4);
    chk("t1_add_en_double", dbl_cnt - dbl_base, 0);

    // 2: most negative operands, 4 * -786432 = -3145728
    for (int i = 0; i < 4; i++) send(-262144, -262144, -262144);
    wait_out();
    chk("t2_out_data", $signed(out_data_a), -3145728);
    chk("t2_sat", sat_a, 0);
    @(negedge clk);

    // 3: 4 * 786429 = 3145716; 22-bit instance wraps or clamps
    for (int i = 0; i < 4; i++) send(262143, 262143, 262143);
    wait_out();
    chk("t3_a_out_data", $signed(out_data_a), 3145716);
    chk("t3_a_sat", sat_a, 0);
    chk("t3_b_valid", out_valid_b, 1);
    chk("t3_b_out_data", $signed(out_data_b), EXP3_B);
    chk("t3_b_sat", sat_b, EXP3_B_SAT);
    chk("t3_b_ch_cnt", ch_cnt_b, 0);
    @(negedge clk);

    // 4: back-pressure in OUT for 5 cycles, result 5+6+7+3 = 21
    out_ready = 1'b0;
    send(5, 0, 0); send(0, 6, 0); send(0, 0, 7); send(1, 1, 1);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", out_valid_a, 1);
      chk("t4_hold_data", $signed(out_data_a), 21);
      chk("t4_hold_in_ready", in_ready_a, 0);
      chk("t4_hold_add_en", add_en_a, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_accept", out_valid_a, 0);
    for (int i = 0; i < 4; i++) send(2, 2, 2);
    wait_out();
    chk("t4_next_data", $signed(out_data_a), 24);
    @(negedge clk);
    chk("t4_next_accept", out_valid_a, 0);

    // 5: clear after two channels, triple offered with clear is refused
    send(9, 9, 9);
    send(9, 9, 9);
    for (int n = 0; n < 20 && in_ready_a !== 1'b1; n++) @(negedge clk);
    chk("t5_ch_before_clear", ch_cnt_a, 2);
    clear = 1'b1; in_valid = 1'b1; in_a = IN_W'(100); in_b = '0; in_c = '0;
    #1;
    chk("t5_in_ready_clear", in_ready_a, 0);
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("t5_ch_after_clear", ch_cnt_a, 0);
    chk("t5_add_en_after_clear", add_en_a, 0);
    for (int i = 0; i < 4; i++) send(1, 1, 1);
    wait_out();
    chk("t5_out_data", $signed(out_data_a), 12);
    @(negedge clk);

    // 6: asynchronous reset while in ISSUE with channel 2 in flight
    send(3, 3, 3);
    send(3, 3, 3);
    send(50, 50, 50);
    chk("t6_pre_add_en", add_en_a, 1);
    chk("t6_pre_ch_cnt", ch_cnt_a, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_add_en", add_en_a, 0);
    chk("t6_rst_out_valid", out_valid_a, 0);
    chk("t6_rst_ch_cnt", ch_cnt_a, 0);
    chk("t6_rst_in_ready", in_ready_a, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(4, 4, 4);
    wait_out();
    chk("t6_out_data", $signed(out_data_a), 48);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
